// File: rtl/dump_pkg.sv
// Shared types for the end-of-program dump sequencer.
// Record kinds, FSM states and record width.
package dump_pkg;

  localparam int REC_W = 32;

  typedef enum logic [1:0] {
    KIND_PC  = 2'd0,
    KIND_REG = 2'd1,
    KIND_MEM = 2'd2
  } kind_t;

  typedef enum logic [2:0] {
    RUN,
    DRAIN,
    REGS,
    MEMS,
    DONE
  } state_t;

endpackage

// File: rtl/dump_fifo.sv
// Synchronous FIFO; push into a full FIFO is ignored unless a pop frees a slot
// in the same cycle. DEPTH must be a power of two (pointers wrap naturally).
module dump_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic             push_en;
  logic             pop_en;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign dout    = mem[rp];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_en) wp <= wp + AW'(1);
      if (pop_en)  rp <= rp + AW'(1);
      unique case ({push_en, pop_en})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wp] <= din;
  end

endmodule

// File: rtl/dump_sequencer.sv
// Captures the machine PC trace, detects end of program, freezes the machine
// and streams PC trace, register file and a memory window as ordered records.
module dump_sequencer
  import dump_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter int          NUM_REGS       = 32,
  parameter logic [31:0] MEM_BASE       = 32'h4000,
  parameter int          MEM_WORDS      = 4,
  parameter int          FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output logic        freeze,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [31:0] mem_raddr,
  input  logic [7:0]  mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_kind,
  output logic        out_last,
  output logic        overflow,
  output logic        done
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  state_t             state;
  state_t             state_n;
  logic [CW-1:0]      cyc_cnt;
  logic [31:0]        idx;
  logic               fifo_full;
  logic               fifo_empty;
  logic [REC_W-1:0]   fifo_dout;
  logic               slot_free;
  logic               last_hs;
  logic               push;
  logic               pop;
  logic               halt;
  logic               reg_last;
  logic               mem_last;
  logic               ld_reg;
  logic               ld_mem;

  dump_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (pc),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    slot_free = !out_valid || out_ready;
    last_hs   = out_valid && out_last && out_ready;
    push      = (state == RUN);
    pop       = ((state == RUN) || (state == DRAIN)) &&
                slot_free && !fifo_empty;
    reg_last  = (idx == 32'(NUM_REGS - 1));
    mem_last  = (idx == 32'(MEM_WORDS - 1));
    ld_reg    = (state == REGS) && slot_free;
    // Once the last record is loaded, hold it until it is accepted.
    ld_mem    = (state == MEMS) && slot_free &&
                !(out_valid && out_last);
    halt      = 1'b0;
    if (inst == 32'h0) halt = 1'b1;
    if (cyc_cnt == CW'(TIMEOUT_CYCLES - 1)) halt = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RUN:   if (halt) state_n = DRAIN;
      DRAIN: if (fifo_empty && slot_free) state_n = REGS;
      REGS:  if (ld_reg && reg_last) state_n = MEMS;
      MEMS:  if (last_hs) state_n = DONE;
      DONE:  state_n = DONE;
      default: state_n = RUN;
    endcase
  end

  always_comb begin
    freeze    = (state != RUN);
    done      = (state == DONE);
    rf_raddr  = (state == REGS) ? idx[4:0] : 5'd0;
    mem_raddr = (state == MEMS) ? (MEM_BASE + idx) : MEM_BASE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt   <= '0;
      overflow  <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_kind  <= KIND_PC;
      out_last  <= 1'b0;
    end else begin
      if (push && (cyc_cnt != '1)) cyc_cnt <= cyc_cnt + CW'(1);
      if (push && fifo_full && !pop) overflow <= 1'b1;
      if (ld_reg)
        idx <= reg_last ? 32'd0 : idx + 32'd1;
      else if (ld_mem && !mem_last)
        idx <= idx + 32'd1;
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= fifo_dout;
        out_kind  <= KIND_PC;
        out_last  <= 1'b0;
      end else if (ld_reg) begin
        out_valid <= 1'b1;
        out_data  <= rf_rdata;
        out_kind  <= KIND_REG;
        out_last  <= 1'b0;
      end else if (ld_mem) begin
        out_valid <= 1'b1;
        out_data  <= {24'b0, mem_rdata};
        out_kind  <= KIND_MEM;
        out_last  <= mem_last;
      end else if (slot_free) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dump_sequencer.sv
// Directed bench for dump_sequencer: halt, timeout, dump contents,
// backpressure and mid-dump reset.
module tb_dump_sequencer;
  import dump_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        freeze;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [31:0] mem_raddr;
  logic [7:0]  mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_kind;
  logic        out_last;
  logic        overflow;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [34:0] recs[$];
  logic [34:0] exp_q[$];
  logic [31:0] exp_pcs[$];
  int          stab_err;
  bit          prev_stall;
  logic [35:0] prev;

  always #5 clk = ~clk;

  function automatic logic [31:0] rfv(input int i);
    case (i)
      5:       return 32'h0;
      6:       return 32'h5;
      7:       return 32'h7FFFFFFF;
      default: return 32'h1000_0000 + 32'(i * 3);
    endcase
  endfunction

  function automatic logic [7:0] memb(input logic [31:0] a);
    if (a == 32'h4002) return 8'hAB;
    return a[7:0] ^ 8'h5A;
  endfunction

  assign rf_rdata  = rfv(int'(rf_raddr));
  assign mem_rdata = memb(mem_raddr);

  dump_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .inst      (inst),
    .pc        (pc),
    .freeze    (freeze),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_kind  (out_kind),
    .out_last  (out_last),
    .overflow  (overflow),
    .done      (done)
  );

  // Inputs change at posedge+1, so a handshake seen here fires on the next edge.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall &&
          ({out_valid, out_kind, out_last, out_data} !== prev))
        stab_err <= stab_err + 1;
      prev       <= {out_valid, out_kind, out_last, out_data};
      prev_stall <= out_valid && !out_ready;
      if (out_valid && out_ready)
        recs.push_back({out_kind, out_last, out_data});
    end
  end

  function automatic logic rdy(input int mode, input int j);
    case (mode)
      1:       return (j >= 10);
      2:       return (j % 3 == 0);
      default: return 1'b1;
    endcase
  endfunction

  task automatic build_exp();
    exp_q.delete();
    foreach (exp_pcs[i]) exp_q.push_back({2'd0, 1'b0, exp_pcs[i]});
    for (int r = 0; r < 32; r++)
      exp_q.push_back({2'd1, 1'b0, rfv(r)});
    for (int m = 0; m < 4; m++)
      exp_q.push_back({2'd2, (m == 3), 24'b0, memb(32'h4000 + 32'(m))});
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    pc        = 32'h0;
    inst      = 32'h13;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_prog(input int zero_at, input int mode,
                          output int fz_edge, output bit fin);
    recs.delete();
    stab_err  = 0;
    fz_edge   = -1;
    fin       = 1'b0;
    pc        = 32'h0;
    inst      = (zero_at == 0) ? 32'h0 : 32'h13;
    out_ready = rdy(mode, 0);
    for (int j = 1; j <= 600; j++) begin
      @(posedge clk);
      #1;
      if (freeze && fz_edge < 0) fz_edge = j;
      if (done) begin
        fin = 1'b1;
        break;
      end
      pc        = 32'(4 * j);
      inst      = (j == zero_at) ? 32'h0 : 32'h13;
      out_ready = rdy(mode, j);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    pc        = 32'h0;
    inst      = 32'h13;
    out_ready = 1'b1;
    #3;
    checks++;
    if ({out_valid, freeze, done, overflow, out_last} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=00000",
               {out_valid, freeze, done, overflow, out_last});
    end
    checks++;
    if (out_data !== 32'h0 || out_kind !== 2'd0) begin
      failures++;
      $display("FAIL reset_data got=%h/%0d want=0/0", out_data, out_kind);
    end
    checks++;
    if (rf_raddr !== 5'd0 || mem_raddr !== 32'h4000) begin
      failures++;
      $display("FAIL reset_addr got=%0d/%h want=0/4000", rf_raddr, mem_raddr);
    end
  endtask

  task automatic test_zero_halt();
    int fe;
    bit fin;
    do_reset();
    run_prog(2, 0, fe, fin);
    exp_pcs = '{32'h0, 32'h4, 32'h8};
    build_exp();
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL zero_done timeout got=0 want=1");
    end
    checks++;
    if (fe != 3) begin
      failures++;
      $display("FAIL zero_freeze_edge got=%0d want=3", fe);
    end
    checks++;
    if (overflow !== 1'b0 || freeze !== 1'b1) begin
      failures++;
      $display("FAIL zero_flags ovf=%b frz=%b want=0/1", overflow, freeze);
    end
    checks++;
    if (recs.size() != exp_q.size()) begin
      failures++;
      $display("FAIL zero_count got=%0d want=%0d", recs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < recs.size(); i++) begin
      checks++;
      if (recs[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL zero_rec[%0d] got=%h want=%h", i, recs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int fe;
    bit fin;
    do_reset();
    run_prog(-1, 0, fe, fin);
    exp_pcs.delete();
    for (int k = 0; k < 64; k++) exp_pcs.push_back(32'(4 * k));
    build_exp();
    checks++;
    if (!fin || fe != 64) begin
      failures++;
      $display("FAIL tmo_freeze fin=%b edge=%0d want=1/64", fin, fe);
    end
    checks++;
    if (recs.size() != exp_q.size()) begin
      failures++;
      $display("FAIL tmo_count got=%0d want=%0d", recs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < recs.size(); i++) begin
      checks++;
      if (recs[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL tmo_rec[%0d] got=%h want=%h", i, recs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_dump_contents();
    int fe;
    bit fin;
    bit seen;
    do_reset();
    seen = 1'b0;
    fork
      begin
        run_prog(2, 0, fe, fin);
      end
      begin
        for (int c = 0; c < 300 && !seen; c++) begin
          @(negedge clk);
          if (mem_raddr == 32'h4002 && mem_rdata == 8'hAB) seen = 1'b1;
        end
      end
    join
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL dump_addr4002 got=0 want=1");
    end
    checks++;
    if (recs.size() < 39) begin
      failures++;
      $display("FAIL dump_count got=%0d want=39", recs.size());
    end else begin
      checks += 3;
      if (recs[8] !== {2'd1, 1'b0, 32'h0}) begin
        failures++;
        $display("FAIL dump_r5 got=%h want=%h", recs[8], {2'd1, 1'b0, 32'h0});
      end
      if (recs[9] !== {2'd1, 1'b0, 32'h5}) begin
        failures++;
        $display("FAIL dump_r6 got=%h want=%h", recs[9], {2'd1, 1'b0, 32'h5});
      end
      if (recs[10] !== {2'd1, 1'b0, 32'h7FFFFFFF}) begin
        failures++;
        $display("FAIL dump_r7 got=%h want=%h", recs[10],
                 {2'd1, 1'b0, 32'h7FFFFFFF});
      end
      checks++;
      if (recs[37] !== {2'd2, 1'b0, 32'h000000AB}) begin
        failures++;
        $display("FAIL dump_mem2 got=%h want=%h", recs[37],
                 {2'd2, 1'b0, 32'h000000AB});
      end
    end
  endtask

  task automatic test_backpressure();
    int fe;
    bit fin;
    do_reset();
    run_prog(20, 1, fe, fin);
    exp_pcs.delete();
    for (int k = 0; k <= 4; k++)   exp_pcs.push_back(32'(4 * k));
    for (int k = 10; k <= 20; k++) exp_pcs.push_back(32'(4 * k));
    build_exp();
    checks++;
    if (!fin || overflow !== 1'b1) begin
      failures++;
      $display("FAIL bp_overflow fin=%b ovf=%b want=1/1", fin, overflow);
    end
    checks++;
    if (stab_err != 0) begin
      failures++;
      $display("FAIL bp_stable changes=%0d want=0", stab_err);
    end
    checks++;
    if (recs.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bp_count got=%0d want=%0d", recs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < recs.size(); i++) begin
      checks++;
      if (recs[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_rec[%0d] got=%h want=%h", i, recs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_toggle_ready();
    int fe;
    bit fin;
    do_reset();
    run_prog(2, 2, fe, fin);
    exp_pcs = '{32'h0, 32'h4, 32'h8};
    build_exp();
    checks++;
    if (!fin || overflow !== 1'b0 || stab_err != 0) begin
      failures++;
      $display("FAIL tog_flags fin=%b ovf=%b stab=%0d want=1/0/0",
               fin, overflow, stab_err);
    end
    checks++;
    if (recs.size() != exp_q.size()) begin
      failures++;
      $display("FAIL tog_count got=%0d want=%0d", recs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < recs.size(); i++) begin
      checks++;
      if (recs[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL tog_rec[%0d] got=%h want=%h", i, recs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int  fe;
    bit  fin;
    bit  hit;
    do_reset();
    hit       = 1'b0;
    pc        = 32'h0;
    inst      = 32'h13;
    out_ready = 1'b1;
    for (int j = 1; j <= 200; j++) begin
      @(posedge clk);
      #1;
      if (freeze && rf_raddr == 5'd10) begin
        hit = 1'b1;
        break;
      end
      pc   = 32'(4 * j);
      inst = (j == 2) ? 32'h0 : 32'h13;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL mid_reach_idx10 got=0 want=1");
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, freeze, done, out_last} !== 4'b0 ||
        rf_raddr !== 5'd0 || mem_raddr !== 32'h4000) begin
      failures++;
      $display("FAIL mid_async got=%b/%0d/%h want=0000/0/4000",
               {out_valid, freeze, done, out_last}, rf_raddr, mem_raddr);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    run_prog(-1, 0, fe, fin);
    checks++;
    if (!fin || fe != 64) begin
      failures++;
      $display("FAIL mid_rerun fin=%b edge=%0d want=1/64", fin, fe);
    end
    checks++;
    if (recs.size() != 100 || recs[0] !== 35'h0 ||
        recs[63] !== {2'd0, 1'b0, 32'd252}) begin
      failures++;
      $display("FAIL mid_rerun_recs n=%0d first=%h want=100/0", recs.size(),
               (recs.size() > 0) ? recs[0] : 35'h7FFFFFFFF);
    end
  endtask

  initial begin
    test_reset();
    test_zero_halt();
    test_timeout();
    test_dump_contents();
    test_backpressure();
    test_toggle_ready();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dump_sequencer.md
# dump_sequencer

Observation block downstream of `machine`. It captures the PC of every executed cycle and detects end of program: an all-zero instruction or a cycle timeout. It then freezes the machine and walks the register file and a data-memory window. Everything is emitted as one ordered record stream (PC trace, then registers, then memory) over a valid/ready handshake, ready for the autograder comparator.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: maximum PC records captured before a forced halt.
- `NUM_REGS`, 32: registers dumped, indices 0..NUM_REGS-1.
- `MEM_BASE`, 32'h4000: first data-memory byte address dumped.
- `MEM_WORDS`, 4: memory entries dumped, MEM_BASE..MEM_BASE+MEM_WORDS-1.
- `FIFO_DEPTH`, 4: PC trace buffer depth; must be a power of two.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state immediately.
- `inst`, in, 32: current machine instruction.
- `pc`, in, 32: current byte PC, i.e. `{PC_reg.q, 2'b00}`.
- `freeze`, out, 1: machine clock-enable hold, high from halt detection onward.
- `rf_raddr`, out, 5: register-file read index; combinational read.
- `rf_rdata`, in, 32: register-file read data, same cycle as `rf_raddr`.
- `mem_raddr`, out, 32: data-memory byte address; combinational read.
- `mem_rdata`, in, 8: data-memory byte.
- `out_valid`, out, 1: record valid.
- `out_ready`, in, 1: consumer accepts the record.
- `out_data`, out, 32: record payload; memory bytes are zero-extended.
- `out_kind`, out, 2: record type, 0 = PC, 1 = REG, 2 = MEM.
- `out_last`, out, 1: marks the final MEM record.
- `overflow`, out, 1: sticky; at least one PC record was dropped.
- `done`, out, 1: sticky; the final record has been accepted.

## Operation
- **States:** RUN → DRAIN → REGS → MEMS → DONE.
- **RUN:**
  - Every rising edge pushes `pc` into the FIFO and increments `cyc_cnt`.
  - A push into a full FIFO is dropped and sets `overflow`; `cyc_cnt` still increments.
  - The FIFO drains to the output register concurrently.
- **Halt condition**, evaluated at each RUN edge: `inst == 32'h0` or `cyc_cnt == TIMEOUT_CYCLES-1`.
  - The PC of the halting edge is still pushed.
  - The next state is DRAIN, and `freeze` rises on that same edge.
- **DRAIN:** no pushes; pop the FIFO to the output. Leave for REGS when the FIFO is empty and the output register is empty or being accepted.
- **REGS:** index `idx` runs 0..NUM_REGS-1.
  - `rf_raddr = idx`.
  - Load record {REG, `rf_rdata`} when the output slot frees, then increment `idx`.
  - After the last index, go to MEMS with `idx` = 0.
- **MEMS:** `mem_raddr = MEM_BASE + idx`; record {MEM, `{24'b0, mem_rdata}`}. The final entry sets `out_last`.
- **DONE:** entered when the `out_last` record handshakes; sets `done`. State holds until `reset`, with `freeze` staying high.
- **Output register:**
  - Single entry.
  - The slot is free when `!out_valid || out_ready`.
  - While `out_valid` and not `out_ready`, all output fields are stable.
- **Arithmetic:** `cyc_cnt` is `$clog2(TIMEOUT_CYCLES)+1` bits and saturates. `mem_raddr` is 32-bit, wrapping modulo 2^32.

## Timing
- **Reset values:** state RUN; `out_valid`, `out_data`, `out_kind`, `out_last`, `freeze`, `done`, `overflow` all 0; `rf_raddr` 0; `mem_raddr` MEM_BASE; FIFO empty; `cyc_cnt` 0.
- **PC latency:** `pc` sampled at edge N appears on `out_data` after edge N+1 at the earliest (FIFO plus output register).
- **Dump latency:** register/memory read data is registered into the output on the edge where the slot frees. With continuous `out_ready`, one record is emitted per cycle.
- **Record count:** captured PCs minus dropped, plus NUM_REGS, plus MEM_WORDS.
- **Simultaneous events:**
  - `inst == 0` on the timeout edge counts as a single halt.
  - A pop and a push in the same cycle on a full FIFO accepts the push; no overflow.
- **Reset mid-dump:** async abort; `freeze` drops immediately and capture restarts in RUN.
- **Unknown `inst`:** X/Z is not zero and does not halt.

## Structure
- `dump_pkg` holds:
  - `kind_t` enum (KIND_PC=0, KIND_REG=1, KIND_MEM=2).
  - `state_t` enum (RUN, DRAIN, REGS, MEMS, DONE).
  - `REC_W` = 32.
- Sub-module `dump_fifo`: parameterised depth/width synchronous FIFO with `full`/`empty`, push-when-full ignored, and simultaneous push+pop when full allowed.

## Test plan
- **Halt on zero instruction:** `pc` 0x0, 0x4, 0x8; `inst` = 0 at the third edge; `out_ready` = 1 → PC records 0x0, 0x4, 0x8, then 32 REG records, then 4 MEM records with `out_last` on the fourth; `done` = 1; `overflow` = 0.
- **Timeout:** `inst` never 0 → exactly 64 PC records; `freeze` rises after the 64th capture.
- **Dump contents:** model r5=0, r6=5, r7=0x7FFFFFFF, byte 0x4002=0xAB → REG records 5..7 carry those values; the third MEM record is 0x000000AB with `mem_raddr` 0x4002.
- **Backpressure:** `out_ready` low for 10 cycles during RUN → `overflow` = 1, exactly FIFO_DEPTH+1 early PCs retained; fields stable while stalled; nothing lost in REGS/MEMS under 1-of-3 ready toggling.
- **Reset mid-REGS:** assert `reset` at `idx` = 10 → outputs return to reset values asynchronously; the rerun emits from PC capture with `cyc_cnt` restarted.
